// File: rtl/load_store_unit_if.sv
// Bundle of the request/response handshake and the datamem word port
// used by load_store_unit. The slave modport is the LSU's view; the
// master modport is the environment (execute stage plus datamem).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word-addressed
// datamem. Sub-word stores use read-modify-write; loads are lane-extracted
// and sign/zero extended (little-endian). All outputs are registered.
// Optional feature macro: LSU_ERR_CHECK_EN (alignment, size and range
// checking with rsp_err). Without it misaligned accesses are aligned down,
// size 11 acts as word and rsp_err stays 0.
module load_store_unit #(
    parameter int MEM_DEPTH = 128
) (
    input logic               clk,
    input logic               reset_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state, state_next;

    logic        lat_store;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_lane;
    logic [15:0] lat_wdata;

    logic        ready_q, ready_next;
    logic        rsp_valid_q, rsp_valid_next;
    logic [31:0] rsp_rdata_q, rsp_rdata_next;
    logic        rsp_err_q, rsp_err_next;
    logic        mem_we_q, mem_we_next;
    logic [31:0] mem_addr_q, mem_addr_next;
    logic [31:0] mem_wdata_q, mem_wdata_next;

    logic        accept;
    logic [1:0]  size_eff;
    logic        req_err;

    assign accept = bus.req_valid & ready_q;

`ifdef LSU_ERR_CHECK_EN
    assign size_eff = bus.req_size;
    assign req_err  = (bus.req_size == 2'b11)
                    | ((bus.req_size == SIZE_HALF) & bus.req_addr[0])
                    | ((bus.req_size == SIZE_WORD) & (bus.req_addr[1:0] != 2'b00))
                    | ({2'b00, bus.req_addr[31:2]} >= $unsigned(MEM_DEPTH));
`else
    assign size_eff = (bus.req_size == 2'b11) ? SIZE_WORD : bus.req_size;
    assign req_err  = 1'b0;
`endif

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic sgn);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = word >> {lane, 3'b000};
        half    = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: extract = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: extract = {{16{sgn & half[15]}}, half};
            default:   extract = word;
        endcase
    endfunction

    // Replace only the addressed byte/half lane of the word that was read.
    function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic [15:0] wdata);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == SIZE_BYTE) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'h0, wdata[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            data = {16'h0, wdata} << {lane[1], 4'b0000};
        end
        merge = (word & ~mask) | (data & mask);
    endfunction

    // State register; reset aborts any in-flight access straight to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Capture the request fields needed after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_store  <= 1'b0;
            lat_size   <= SIZE_BYTE;
            lat_signed <= 1'b0;
            lat_lane   <= 2'b00;
            lat_wdata  <= 16'h0;
        end else if (accept) begin
            lat_store  <= bus.req_store;
            lat_size   <= size_eff;
            lat_signed <= bus.req_signed;
            lat_lane   <= bus.req_addr[1:0];
            lat_wdata  <= bus.req_wdata[15:0];
        end
    end

    // Next state and next registered outputs; outputs describe the state being entered.
    always_comb begin
        state_next     = state;
        ready_next     = 1'b0;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = 32'h0;
        rsp_err_next   = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_q;
        mem_wdata_next = mem_wdata_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    mem_addr_next = {2'b00, bus.req_addr[31:2]};
                    if (req_err) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                    end else if (bus.req_store && size_eff == SIZE_WORD) begin
                        state_next     = WR;
                        mem_we_next    = 1'b1;
                        mem_wdata_next = bus.req_wdata;
                    end else begin
                        state_next = RD;
                    end
                end else begin
                    ready_next = 1'b1;
                end
            end
            RD: begin
                if (lat_store) begin
                    state_next     = WR;
                    mem_we_next    = 1'b1;
                    mem_wdata_next = merge(bus.mem_rdata, lat_size, lat_lane, lat_wdata);
                end else begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = extract(bus.mem_rdata, lat_size, lat_lane, lat_signed);
                end
            end
            WR: begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
            end
            RESP: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    // Output registers; mem_we falls asynchronously with reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            ready_q     <= ready_next;
            rsp_valid_q <= rsp_valid_next;
            rsp_rdata_q <= rsp_rdata_next;
            rsp_err_q   <= rsp_err_next;
            mem_we_q    <= mem_we_next;
            mem_addr_q  <= mem_addr_next;
            mem_wdata_q <= mem_wdata_next;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word RAM.
// Expectations follow the LSU_ERR_CHECK_EN setting of the build.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_DEPTH(128)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Behavioural datamem, 256 words so index 128 exists when checks are off.
    logic [31:0] tb_mem [0:255];
    assign bus.mem_rdata = tb_mem[bus.mem_addr[7:0]];

    // Synchronous write port of the RAM model.
    always @(posedge clk) begin
        if (bus.mem_we) tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    int          checks = 0;
    int          failures = 0;
    int          lat;
    int          we_count;
    logic        got_rsp;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] we_addr;
    logic [31:0] we_data;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request and follow it until rsp_valid, recording latency and writes.
    task automatic apply_stimulus(input logic store, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.req_valid  = 1'b1;
        bus.req_store  = store;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        we_count = 0;
        we_addr = 32'h0;
        we_data = 32'h0;
        got_rsp = 1'b0;
        rdata = 32'h0;
        err = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_we) begin
                we_count++;
                we_addr = bus.mem_addr;
                we_data = bus.mem_wdata;
            end
            if (bus.rsp_valid) begin
                got_rsp = 1'b1;
                rdata = bus.rsp_rdata;
                err = bus.rsp_err;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_txn(input string tag, input int exp_lat, input int exp_we,
                             input logic [31:0] exp_rdata, input logic exp_err);
        check_output({tag, "_rsp_seen"}, {31'd0, got_rsp}, 32'd1);
        check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_output({tag, "_we_cycles"}, 32'(we_count), 32'(exp_we));
        check_output({tag, "_rdata"}, rdata, exp_rdata);
        check_output({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check_output("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_output("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_output("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check_output("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check_output("rst_mem_addr", bus.mem_addr, 32'h0);
        check_output("rst_mem_wdata", bus.mem_wdata, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] word store and load");
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check_txn("wst", 2, 1, 32'h0, 1'b0);
        check_output("wst_addr", we_addr, 32'd4);
        check_output("wst_data", we_data, 32'hDEADBEEF);
        check_output("wst_ram", tb_mem[4], 32'hDEADBEEF);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check_txn("wld", 2, 0, 32'hDEADBEEF, 1'b0);

        $display("[TB] byte store read-modify-write");
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        apply_stimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA);
        check_txn("bst", 3, 1, 32'h0, 1'b0);
        check_output("bst_addr", we_addr, 32'd4);
        check_output("bst_data", we_data, 32'h1122AA44);
        check_output("bst_ram", tb_mem[4], 32'h1122AA44);

        $display("[TB] byte loads with extension");
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF0000);
        apply_stimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        check_txn("bld_s", 2, 0, 32'hFFFFFF80, 1'b0);
        apply_stimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        check_txn("bld_u", 2, 0, 32'h00000080, 1'b0);
        apply_stimulus(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
        check_txn("bld_s2", 2, 0, 32'hFFFFFFFF, 1'b0);

        $display("[TB] half loads and store");
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001FFFF);
        apply_stimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        check_txn("hld_s", 2, 0, 32'hFFFF8001, 1'b0);
        apply_stimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        check_txn("hld_u", 2, 0, 32'h0000FFFF, 1'b0);
        apply_stimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF);
        check_txn("hst", 3, 1, 32'h0, 1'b0);
        check_output("hst_data", we_data, 32'hBEEFFFFF);

        $display("[TB] misaligned half, out-of-range word, size 11");
        apply_stimulus(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
`ifdef LSU_ERR_CHECK_EN
        check_txn("hmis", 1, 0, 32'h0, 1'b1);
`else
        check_txn("hmis", 2, 0, 32'h0000FFFF, 1'b0);
`endif
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678);
`ifdef LSU_ERR_CHECK_EN
        check_txn("oor_st", 1, 0, 32'h0, 1'b1);
`else
        check_txn("oor_st", 2, 1, 32'h0, 1'b0);
        check_output("oor_addr", we_addr, 32'd128);
        check_output("oor_ram", tb_mem[128], 32'h12345678);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
        check_txn("oor_ld", 2, 0, 32'h12345678, 1'b0);
`endif
        apply_stimulus(1'b1, 2'b11, 1'b0, 32'h20, 32'hCAFEF00D);
`ifdef LSU_ERR_CHECK_EN
        check_txn("sz11", 1, 0, 32'h0, 1'b1);
`else
        check_txn("sz11", 2, 1, 32'h0, 1'b0);
        check_output("sz11_addr", we_addr, 32'd8);
        check_output("sz11_data", we_data, 32'hCAFEF00D);
`endif

        $display("[TB] reset during write of a byte store");
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h14, 32'h55555555);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h14;
        bus.req_wdata  = 32'h00000077;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check_output("mid_we", {31'd0, bus.mem_we}, 32'd1);
        check_output("mid_addr", bus.mem_addr, 32'd5);
        check_output("mid_data", bus.mem_wdata, 32'h55555577);
        reset_n = 1'b0;
        #1;
        check_output("abort_we", {31'd0, bus.mem_we}, 32'd0);
        check_output("abort_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check_output("abort_ram", tb_mem[5], 32'h55555555);
        check_output("abort_rsp2", {31'd0, bus.rsp_valid}, 32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_output("post_ready", {31'd0, bus.req_ready}, 32'd1);
        check_output("post_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        check_txn("post_ld", 2, 0, 32'h55555555, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
